// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle sequencer with C/Z flags and return stack; CTRL_PERF_CNT_EN adds instr_retired
module multicycle_controller #(
  parameter int PC_W        = 12,
  parameter int STACK_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [18:0]     ir,
  input  logic [PC_W-1:0] pc_cur,
  input  logic            alu_zero,
  input  logic            alu_carry,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_sel,
  output logic [PC_W-1:0] ret_addr,
  output logic [2:0]      alu_op,
  output logic            alu_src,
  output logic            carry_in,
  output logic            rf_write,
  output logic            wb_sel,
  output logic            mem_read,
  output logic            mem_write,
  output logic            halted,
  output logic            stk_err
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [15:0]     instr_retired
`endif
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  localparam logic [1:0] CLS_MEM  = 2'b10;
  localparam logic [2:0] OP_LDM   = 3'b000;
  localparam logic [2:0] OP_STM   = 3'b001;
  localparam logic [2:0] OP_JSB   = 3'b001;
  localparam logic [2:0] OP_RET   = 3'b010;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, HALT
  } state_t;

  state_t          state;
  logic            c_flag;
  logic            z_flag;
  logic [PTR_W:0]  sp;
  logic [PC_W-1:0] stack [STACK_DEPTH];

  logic [1:0]       cls;
  logic [2:0]       op;
  logic             stk_full;
  logic             stk_empty;
  logic             stk_fault;
  logic             take;
  logic [PTR_W-1:0] top_idx;
  logic             unused_ir;

  assign cls       = ir[18:17];
  assign op        = ir[16:14];
  assign unused_ir = ^ir[13:0];
  assign stk_full  = sp[PTR_W];
  assign stk_empty = (sp == '0);
  assign top_idx   = sp[PTR_W-1:0] - PTR_W'(1);
  assign ret_addr  = stk_empty ? '0 : stack[top_idx];
  // Only meaningful while a CTRL instruction sits in BRANCH.
  assign stk_fault = (op == OP_JSB && stk_full) || (op == OP_RET && stk_empty);
  assign carry_in  = c_flag;
  assign halted    = (state == HALT);

  always_comb begin
    take = 1'b0;
    case (op)
      3'b000:  take = 1'b1;
      3'b001:  take = !stk_full;
      3'b010:  take = !stk_empty;
      3'b011:  take = z_flag;
      3'b100:  take = !z_flag;
      3'b101:  take = c_flag;
      3'b110:  take = !c_flag;
      default: take = 1'b0;
    endcase
  end

  // Enables are masked during rst so a reset mid-instruction never writes anything.
  always_comb begin
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 2'b00;
    alu_op    = 3'b000;
    alu_src   = 1'b0;
    rf_write  = 1'b0;
    wb_sel    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
        EXEC: begin
          alu_op  = op;
          alu_src = ir[17];
        end
        ALU_WB:   rf_write = 1'b1;
        MEM_ADDR: alu_src = 1'b1;
        MEM_RD:   mem_read = 1'b1;
        MEM_WB: begin
          mem_read = 1'b1;
          rf_write = 1'b1;
          wb_sel   = 1'b1;
        end
        MEM_WR:   mem_write = 1'b1;
        BRANCH: begin
          pc_sel   = (op == OP_RET) ? 2'b10 : 2'b01;
          pc_write = take;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
      sp      <= '0;
      stk_err <= 1'b0;
    end else begin
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          case (cls)
            2'b00, 2'b01: state <= EXEC;
            CLS_MEM:      state <= (op == OP_LDM || op == OP_STM) ? MEM_ADDR : FETCH;
            default:      state <= (op == OP_HALT) ? HALT : BRANCH;
          endcase
        end
        EXEC: begin
          c_flag <= alu_carry;
          z_flag <= alu_zero;
          state  <= ALU_WB;
        end
        ALU_WB:   state <= FETCH;
        MEM_ADDR: state <= (op == OP_LDM) ? MEM_RD : MEM_WR;
        MEM_RD:   state <= MEM_WB;
        MEM_WB:   state <= FETCH;
        MEM_WR:   state <= FETCH;
        BRANCH: begin
          if (stk_fault) begin
            stk_err <= 1'b1;
            state   <= HALT;
          end else begin
            if (op == OP_JSB) begin
              stack[sp[PTR_W-1:0]] <= pc_cur;
              sp <= sp + (PTR_W+1)'(1);
            end else if (op == OP_RET) begin
              sp <= sp - (PTR_W+1)'(1);
            end
            state <= FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic retire;

  always_comb begin
    retire = 1'b0;
    case (state)
      ALU_WB, MEM_WB, MEM_WR: retire = 1'b1;
      DECODE:  retire = (cls == CLS_MEM) && !(op == OP_LDM || op == OP_STM);
      BRANCH:  retire = !stk_fault;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      instr_retired <= '0;
    else if (retire && instr_retired != 16'hFFFF)
      instr_retired <= instr_retired + 16'd1;
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller; CTRL_PERF_CNT_EN checks instr_retired
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] ir = '0;
  logic [11:0] pc_cur = '0;
  logic        alu_zero = 1'b0;
  logic        alu_carry = 1'b0;
  logic        ir_write, pc_write, alu_src, carry_in, rf_write, wb_sel;
  logic        mem_read, mem_write, halted, stk_err;
  logic [1:0]  pc_sel;
  logic [2:0]  alu_op;
  logic [11:0] ret_addr;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0] instr_retired;
`endif

  multicycle_controller #(.PC_W(12), .STACK_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .ir(ir), .pc_cur(pc_cur),
    .alu_zero(alu_zero), .alu_carry(alu_carry),
    .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .ret_addr(ret_addr), .alu_op(alu_op), .alu_src(alu_src),
    .carry_in(carry_in), .rf_write(rf_write), .wb_sel(wb_sel),
    .mem_read(mem_read), .mem_write(mem_write), .halted(halted),
    .stk_err(stk_err)
`ifdef CTRL_PERF_CNT_EN
    , .instr_retired(instr_retired)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [26:0] exp_q[$];
  logic [11:0] m_stack[$];
  logic        m_c, m_z, m_err;
  int          m_ret;

  wire [26:0] obs = {ret_addr, ir_write, pc_write, pc_sel, alu_op, alu_src,
                     rf_write, wb_sel, mem_read, mem_write, halted, stk_err, carry_in};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] ev(input logic [11:0] ra, input logic iw, input logic pw,
                                     input logic [1:0] ps, input logic [2:0] aop,
                                     input logic asrc, input logic rfw, input logic wbs,
                                     input logic mr, input logic mw, input logic hlt,
                                     input logic se, input logic ci);
    return {ra, iw, pw, ps, aop, asrc, rfw, wbs, mr, mw, hlt, se, ci};
  endfunction

  function automatic logic [11:0] m_top();
    return (m_stack.size() > 0) ? m_stack[m_stack.size()-1] : 12'h000;
  endfunction

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    #1 check("rst_enables", {27'd0, ir_write, pc_write, rf_write, mem_read, mem_write}, 32'd0);
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    m_c = 1'b0; m_z = 1'b0; m_err = 1'b0; m_ret = 0;
    m_stack.delete();
`ifdef CTRL_PERF_CNT_EN
    #1 check("perf_reset", {16'd0, instr_retired}, 32'd0);
`endif
  endtask

  // Push the expected per-cycle outputs for one instruction, then compare cycle by cycle.
  task automatic issue(input string tag, input logic [18:0] instr, input logic [11:0] pcv,
                       input logic ac, input logic az, input int limit);
    logic [1:0] cls;
    logic [2:0] op;
    logic       take, fault, halt, retire;
    cls = instr[18:17];
    op  = instr[16:14];
    ir = instr; pc_cur = pcv; alu_carry = ac; alu_zero = az;
    halt = 1'b0; retire = 1'b0; take = 1'b0;
    exp_q.push_back(ev(m_top(), 1, 1, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, m_err, m_c));
    exp_q.push_back(ev(m_top(), 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, m_err, m_c));
    case (cls)
      2'b00, 2'b01: begin
        exp_q.push_back(ev(m_top(), 0, 0, 2'b00, op, cls[0], 0, 0, 0, 0, 0, m_err, m_c));
        m_c = ac; m_z = az;
        exp_q.push_back(ev(m_top(), 0, 0, 2'b00, 3'b000, 0, 1, 0, 0, 0, 0, m_err, m_c));
        retire = 1'b1;
      end
      2'b10: begin
        if (op == 3'b000 || op == 3'b001)
          exp_q.push_back(ev(m_top(), 0, 0, 2'b00, 3'b000, 1, 0, 0, 0, 0, 0, m_err, m_c));
        if (op == 3'b000) begin
          exp_q.push_back(ev(m_top(), 0, 0, 2'b00, 3'b000, 0, 0, 0, 1, 0, 0, m_err, m_c));
          exp_q.push_back(ev(m_top(), 0, 0, 2'b00, 3'b000, 0, 1, 1, 1, 0, 0, m_err, m_c));
        end else if (op == 3'b001) begin
          exp_q.push_back(ev(m_top(), 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 1, 0, m_err, m_c));
        end
        retire = 1'b1;
      end
      default: begin
        if (op == 3'b111) begin
          halt = 1'b1;
        end else begin
          case (op)
            3'b000: take = 1'b1;
            3'b001: take = (m_stack.size() < 8);
            3'b010: take = (m_stack.size() > 0);
            3'b011: take = m_z;
            3'b100: take = !m_z;
            3'b101: take = m_c;
            default: take = !m_c;
          endcase
          exp_q.push_back(ev(m_top(), 0, take, (op == 3'b010) ? 2'b10 : 2'b01, 3'b000,
                             0, 0, 0, 0, 0, 0, m_err, m_c));
          fault = (op == 3'b001 && m_stack.size() == 8) || (op == 3'b010 && m_stack.size() == 0);
          if (fault) begin
            m_err = 1'b1;
            halt = 1'b1;
          end else begin
            retire = 1'b1;
            if (op == 3'b001) m_stack.push_back(pcv);
            if (op == 3'b010) void'(m_stack.pop_back());
          end
        end
      end
    endcase
    if (halt)
      repeat (2) exp_q.push_back(ev(m_top(), 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 1, m_err, m_c));
    for (int k = 0; exp_q.size() > 0; k++) begin
      #1 check($sformatf("%s_c%0d", tag, k), {5'd0, obs}, {5'd0, exp_q.pop_front()});
      if (k + 1 == limit) begin
        exp_q.delete();
        break;
      end
      @(negedge clk);
    end
    if (limit == 0 && retire) m_ret++;
`ifdef CTRL_PERF_CNT_EN
    if (limit == 0) #1 check({tag, "_perf"}, {16'd0, instr_retired}, m_ret);
`endif
  endtask

  function automatic logic [18:0] mk(input logic [1:0] cls, input logic [2:0] op, input logic [13:0] lo);
    return {cls, op, lo};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_c = 0; m_z = 0; m_err = 0; m_ret = 0;
    @(negedge clk);
    apply_reset(2);
    issue("r_alu", 19'b00_001_011_001_010_00000, 12'h001, 1'b1, 1'b0, 0);
    issue("i_alu_z", mk(2'b01, 3'b100, 14'h0012), 12'h002, 1'b0, 1'b1, 0);
    issue("stm", mk(2'b10, 3'b001, 14'h0005), 12'h003, 1'b1, 1'b0, 0);
    issue("ldm", mk(2'b10, 3'b000, 14'h0007), 12'h004, 1'b1, 1'b0, 0);
    issue("mem_nop", mk(2'b10, 3'b101, 14'h0000), 12'h005, 1'b0, 1'b0, 0);
    issue("bz_taken", mk(2'b11, 3'b011, 14'h00A5), 12'h006, 1'b0, 1'b0, 0);
    issue("alu_c1z0", mk(2'b00, 3'b010, 14'h0000), 12'h007, 1'b1, 1'b0, 0);
    issue("bz_not", mk(2'b11, 3'b011, 14'h00A5), 12'h008, 1'b0, 1'b0, 0);
    issue("bnz", mk(2'b11, 3'b100, 14'h0033), 12'h009, 1'b0, 1'b0, 0);
    issue("bc", mk(2'b11, 3'b101, 14'h0044), 12'h00A, 1'b0, 1'b0, 0);
    issue("bnc", mk(2'b11, 3'b110, 14'h0055), 12'h00B, 1'b0, 1'b0, 0);
    issue("jmp", mk(2'b11, 3'b000, 14'h0066), 12'h00C, 1'b0, 1'b0, 0);
    issue("jsb", mk(2'b11, 3'b001, 14'h0200), 12'h010, 1'b0, 1'b0, 0);
    issue("ret", mk(2'b11, 3'b010, 14'h0000), 12'h201, 1'b0, 1'b0, 0);
    for (int i = 0; i < 9; i++)
      issue($sformatf("jsb_nest%0d", i), mk(2'b11, 3'b001, 14'h0300), 12'h100 + 12'(i), 1'b0, 1'b0, 0);
    apply_reset(1);
    issue("ret_empty", mk(2'b11, 3'b010, 14'h0000), 12'h001, 1'b0, 1'b0, 0);
    apply_reset(1);
    issue("ldm_abort", mk(2'b10, 3'b000, 14'h0001), 12'h001, 1'b0, 1'b0, 4);
    apply_reset(1);
    issue("alu_post_rst", mk(2'b00, 3'b000, 14'h0000), 12'h001, 1'b1, 1'b1, 0);
    issue("halt", mk(2'b11, 3'b111, 14'h0000), 12'h002, 1'b0, 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
